// File: rtl/seq_bit_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_bit_tx_pkg : shared types and helpers for the serial bit tx    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package seq_bit_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Zero or oversized lengths mean "send the full word".
  function automatic int norm_len(input int len, input int width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_bit_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_bit_tx_fifo : 2-entry synchronous FIFO, async active-low reset |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module seq_bit_tx_fifo #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == 2'd2);
  assign empty  = (r_count == 2'd0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the flushed count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/seq_bit_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_bit_tx : buffered MSB-first serial bit transmitter with gap     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module seq_bit_tx
  import seq_bit_tx_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   LEN_W    = 4,
  parameter int   GAP      = 0,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic             busy
);

  localparam int GAP_W = (clog2(GAP + 1) < 1) ? 1 : clog2(GAP + 1);
  localparam int DW    = WIDTH + LEN_W;
  localparam logic [LEN_W-1:0] c_width    = LEN_W'(WIDTH);
  localparam logic [GAP_W-1:0] c_gap_load = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_sh, w_sh_n;
  logic [LEN_W-1:0] r_rem, w_rem_n;
  logic [GAP_W-1:0] r_gap, w_gap_n;
  logic             r_x, w_x_n;
  logic             r_xv, w_xv_n;
  logic             r_done, w_done_n;
  logic             r_in_ready;

  logic             w_push, w_pop, w_load;
  logic             w_full, w_empty, w_full_n;
  logic [LEN_W-1:0] w_wlen;
  logic [DW-1:0]    w_rdata;
  logic [WIDTH-1:0] w_rd_data, w_ld_sh;
  logic [LEN_W-1:0] w_rd_len;

  assign w_push = in_valid && r_in_ready;
  assign w_wlen = LEN_W'(norm_len(int'(in_len), WIDTH));

  seq_bit_tx_fifo #(.DW(DW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({in_data, w_wlen}),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_rd_data = w_rdata[DW-1:LEN_W];
  assign w_rd_len  = w_rdata[LEN_W-1:0];
  // Left-align so the first bit to send always sits at the MSB.
  assign w_ld_sh   = w_rd_data << (c_width - w_rd_len);

  assign w_full_n  = w_full ? !w_pop : (!w_empty && w_push && !w_pop);

  always_comb begin
    w_state_n = r_state;
    w_sh_n    = r_sh;
    w_rem_n   = r_rem;
    w_gap_n   = r_gap;
    w_x_n     = IDLE_BIT;
    w_xv_n    = 1'b0;
    w_done_n  = 1'b0;
    w_pop     = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_load = 1'b1;
      end
      S_SHIFT: begin
        // r_rem counts bits still to send after the one on x now.
        if (r_rem != '0) begin
          w_x_n    = r_sh[WIDTH-1];
          w_sh_n   = r_sh << 1;
          w_rem_n  = r_rem - LEN_W'(1);
          w_xv_n   = 1'b1;
          w_done_n = (r_rem == LEN_W'(1));
        end else if (GAP > 0) begin
          w_state_n = S_GAP;
          w_gap_n   = c_gap_load;
        end else if (!w_empty) begin
          w_load = 1'b1;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap != '0)   w_gap_n = r_gap - GAP_W'(1);
        else if (!w_empty) w_load = 1'b1;
        else               w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_load) begin
      w_pop     = 1'b1;
      w_state_n = S_SHIFT;
      w_x_n     = w_ld_sh[WIDTH-1];
      w_sh_n    = w_ld_sh << 1;
      w_rem_n   = w_rd_len - LEN_W'(1);
      w_xv_n    = 1'b1;
      w_done_n  = (w_rd_len == LEN_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sh       <= '0;
      r_rem      <= '0;
      r_gap      <= '0;
      r_x        <= IDLE_BIT;
      r_xv       <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_sh       <= w_sh_n;
      r_rem      <= w_rem_n;
      r_gap      <= w_gap_n;
      r_x        <= w_x_n;
      r_xv       <= w_xv_n;
      r_done     <= w_done_n;
      r_in_ready <= !w_full_n;
    end
  end

  assign in_ready = r_in_ready;
  assign x        = r_x;
  assign x_valid  = r_xv;
  assign done     = r_done;
  assign busy     = !w_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_bit_tx : scoreboard bench, one instance with GAP=0, one GAP=2 |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_seq_bit_tx;

  localparam int   WIDTH    = 8;
  localparam int   LEN_W    = 4;
  localparam logic IDLE_BIT = 1'b0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [LEN_W-1:0] in_len = '0;
  logic             in_valid = 1'b0;
  logic a_in_ready, a_x, a_x_valid, a_done, a_busy;
  logic b_in_ready, b_x, b_x_valid, b_done, b_busy;

  int checks = 0;
  int errors = 0;
  logic [1:0] qa[$];
  logic [1:0] qb[$];

  always #5 clk = ~clk;

  seq_bit_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .GAP(0), .IDLE_BIT(IDLE_BIT)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(a_in_ready), .x(a_x), .x_valid(a_x_valid), .done(a_done), .busy(a_busy));

  seq_bit_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .GAP(2), .IDLE_BIT(IDLE_BIT)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(b_in_ready), .x(b_x), .x_valid(b_x_valid), .done(b_done), .busy(b_busy));

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a word is its normalised length of bits, MSB first, last one flagged.
  task automatic expect_word(input logic [WIDTH-1:0] d, input int l);
    int n;
    n = (l == 0 || l > WIDTH) ? WIDTH : l;
    for (int i = n - 1; i >= 0; i--) begin
      qa.push_back({d[i], (i == 0)});
      qb.push_back({d[i], (i == 0)});
    end
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic send(input logic [WIDTH-1:0] d, input int l);
    int n;
    n = 0;
    while (!(a_in_ready && b_in_ready)) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready a=%0b b=%0b expected 1", a_in_ready, b_in_ready);
        return;
      end
    end
    in_data  = d;
    in_len   = LEN_W'(l);
    in_valid = 1'b1;
    @(posedge clk);
    expect_word(d, l);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (a_busy || b_busy) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL idle_timeout: busy a=%0b b=%0b expected 0", a_busy, b_busy);
        return;
      end
    end
  endtask

  // Counts valid cycles and the first-to-last span for each instance.
  task automatic measure(input int n, output int ca, output int sa,
                         output int cb, output int sb, output int nr);
    int fa, la, fb, lb;
    ca = 0; cb = 0; nr = 0; fa = -1; fb = -1; la = 0; lb = 0;
    for (int k = 0; k < n; k++) begin
      if (a_x_valid) begin ca++; if (fa < 0) fa = k; la = k; end
      if (b_x_valid) begin cb++; if (fb < 0) fb = k; lb = k; end
      if (!a_in_ready) nr++;
      @(posedge clk); #1;
    end
    sa = la - fa;
    sb = lb - fb;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_x_valid) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_extra_bit: x=%0b with nothing expected", a_x);
        end else begin
          logic [1:0] e;
          e = qa.pop_front();
          chk("a_bit", a_x, e[1]);
          chk("a_done", a_done, e[0]);
        end
      end else begin
        chk("a_idle_x", a_x, IDLE_BIT);
        chk("a_idle_done", a_done, 0);
      end
      if (b_x_valid) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra_bit: x=%0b with nothing expected", b_x);
        end else begin
          logic [1:0] e;
          e = qb.pop_front();
          chk("b_bit", b_x, e[1]);
          chk("b_done", b_done, e[0]);
        end
      end else begin
        chk("b_idle_x", b_x, IDLE_BIT);
        chk("b_idle_done", b_done, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca, sa, cb, sb, nr, n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", a_x, IDLE_BIT);
    chk("rst_x_valid", a_x_valid | b_x_valid, 0);
    chk("rst_busy", a_busy | b_busy, 0);
    chk("rst_in_ready", a_in_ready | b_in_ready, 0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_before_edge", a_in_ready, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_a", a_in_ready, 1);
    chk("rel_in_ready_b", b_in_ready, 1);
    chk("rel_busy", a_busy | b_busy, 0);
    repeat (3) @(posedge clk);
    #1 chk("idle_x_valid", a_x_valid | b_x_valid, 0);

    // Single word: not bypassed, first bit one cycle later.
    send(8'b0000_0010, 3);
    chk("lat_no_bypass", a_x_valid, 0);
    chk("lat_busy", a_busy, 1);
    @(posedge clk); #1;
    chk("lat_first_a", a_x_valid, 1);
    chk("lat_first_b", b_x_valid, 1);
    wait_idle();
    chk("single_drained", qa.size() + qb.size(), 0);

    fork
      measure(20, ca, sa, cb, sb, nr);
      begin send(8'b111, 3); send(8'b010, 3); end
    join
    chk("b2b_cnt_a", ca, 6);
    chk("b2b_span_a", sa, 5);
    chk("b2b_cnt_b", cb, 6);
    chk("b2b_span_b", sb, 7);
    wait_idle();

    fork
      measure(60, ca, sa, cb, sb, nr);
      begin
        send(8'hC3, 8); send(8'h5A, 8); send(8'h96, 8); send(8'h0F, 8);
      end
    join
    chk("bp_cnt_a", ca, 32);
    chk("bp_span_a", sa, 31);
    chk("bp_cnt_b", cb, 32);
    chk("bp_span_b", sb, 37);
    chk("bp_ready_dropped", (nr > 0) ? 1 : 0, 1);
    wait_idle();

    fork
      measure(24, ca, sa, cb, sb, nr);
      begin send(8'hA5, 0); send(8'h01, 1); end
    join
    chk("len_cnt_a", ca, 9);
    chk("len_span_a", sa, 8);
    chk("len_span_b", sb, 10);
    wait_idle();

    for (int w = 0; w < 30; w++) begin
      send(WIDTH'($urandom), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_idle();
    chk("rand_drained_a", qa.size(), 0);
    chk("rand_drained_b", qb.size(), 0);

    // Reset during the 2nd bit of the gapped instance's second word.
    send(8'b101, 3);
    send(8'b110, 3);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      if (b_x_valid) n++;
      if (n == 5) break;
      @(posedge clk); #1;
    end
    chk("mid_reset_reached", n, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x", b_x, IDLE_BIT);
    chk("mid_rst_x_valid", b_x_valid, 0);
    chk("mid_rst_done", b_done, 0);
    qa.delete();
    qb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("mid_rel_busy", a_busy | b_busy, 0);
    @(posedge clk); #1;
    chk("mid_rel_ready", b_in_ready, 1);
    repeat (8) @(posedge clk);
    #1 chk("mid_rel_quiet", b_busy | b_x_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
